// File: rtl/drop_timer_if.sv
// drop_timer control/status bundle.
// Game FSM side is master, timer is slave.
interface drop_timer_if #(
  parameter int LEVEL_W = 4,
  parameter int CNT_W   = 32
);
  logic               enable;
  logic               pause;
  logic               restart;
  logic               soft_drop;
  logic [LEVEL_W-1:0] level;
  logic               tick;
  logic [CNT_W-1:0]   tick_count;
  logic               running;
  logic               paused;

  modport master (
    output enable, pause, restart, soft_drop, level,
    input  tick, tick_count, running, paused
  );

  modport slave (
    input  enable, pause, restart, soft_drop, level,
    output tick, tick_count, running, paused
  );
endinterface

// File: rtl/drop_timer.sv
// Gravity timer: clock -> units -> level-scaled
// drop interval, one-cycle tick per interval.
module drop_timer #(
  parameter int CLK_PER_UNIT = 1000000,
  parameter int BASE_UNITS   = 10,
  parameter int STEP_UNITS   = 1,
  parameter int MIN_UNITS    = 1,
  parameter int SOFT_UNITS   = 1,
  parameter int LEVEL_W      = 4,
  parameter int CNT_W        = 32
) (
  input logic        clk,
  input logic        rst,
  drop_timer_if.slave tmr
);

  localparam int UNIT_W = $clog2(CLK_PER_UNIT);
  localparam int DROP_W =
    (BASE_UNITS > 1) ? $clog2(BASE_UNITS) : 1;
  localparam int PROD_W = LEVEL_W + 32;

  localparam logic [UNIT_W-1:0] UNIT_LAST =
    UNIT_W'(CLK_PER_UNIT - 1);
  localparam logic [PROD_W-1:0] HEADROOM =
    PROD_W'(BASE_UNITS - MIN_UNITS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [UNIT_W-1:0] unit_cnt_q;
  logic [DROP_W-1:0] drop_cnt_q;
  logic [CNT_W-1:0]  tick_count_q;
  logic              tick_q;
  logic              running_q;
  logic              paused_q;

  logic [PROD_W-1:0] prod;
  logic [31:0]       norm_units;
  logic [31:0]       period_units;
  logic              drop_hit;
  logic              count_en;

  assign prod = PROD_W'(tmr.level) * PROD_W'(STEP_UNITS);

  // Period from level/soft drop, clamped without underflow.
  always_comb begin
    norm_units = 32'(MIN_UNITS);
    if (prod < HEADROOM)
      norm_units = 32'(BASE_UNITS) - prod[31:0];
    period_units = norm_units;
    if (tmr.soft_drop && (32'(SOFT_UNITS) < norm_units))
      period_units = 32'(SOFT_UNITS);
  end

  // >= so a shortened period fires at the next boundary.
  assign drop_hit =
    (32'(drop_cnt_q) + 32'd1) >= period_units;

  // The resume edge out of PAUSED counts, so a pause
  // costs exactly as many cycles as pause is held.
  assign count_en = (state_q != IDLE) && !tmr.pause;

  // Next state: restart holds state, enable low wins next.
  always_comb begin
    state_d = state_q;
    if (!tmr.restart) begin
      if (!tmr.enable) begin
        state_d = IDLE;
      end else begin
        unique case (state_q)
          IDLE:    state_d = RUN;
          RUN:     if (tmr.pause) state_d = PAUSED;
          PAUSED:  if (!tmr.pause) state_d = RUN;
          default: state_d = IDLE;
        endcase
      end
    end
  end

  // State, decoded status and the unit/drop/tick counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      running_q    <= 1'b0;
      paused_q     <= 1'b0;
      tick_q       <= 1'b0;
      unit_cnt_q   <= '0;
      drop_cnt_q   <= '0;
      tick_count_q <= '0;
    end else begin
      state_q   <= state_d;
      running_q <= (state_d == RUN);
      paused_q  <= (state_d == PAUSED);
      tick_q    <= 1'b0;
      if (tmr.restart) begin
        unit_cnt_q   <= '0;
        drop_cnt_q   <= '0;
        tick_count_q <= '0;
      end else if (!tmr.enable) begin
        unit_cnt_q <= '0;
        drop_cnt_q <= '0;
      end else if (count_en) begin
        if (unit_cnt_q == UNIT_LAST) begin
          unit_cnt_q <= '0;
          if (drop_hit) begin
            drop_cnt_q   <= '0;
            tick_q       <= 1'b1;
            tick_count_q <= tick_count_q + CNT_W'(1);
          end else begin
            drop_cnt_q <= drop_cnt_q + DROP_W'(1);
          end
        end else begin
          unit_cnt_q <= unit_cnt_q + UNIT_W'(1);
        end
      end
    end
  end

  assign tmr.tick       = tick_q;
  assign tmr.tick_count = tick_count_q;
  assign tmr.running    = running_q;
  assign tmr.paused     = paused_q;

endmodule

// File: tb/tb_drop_timer.sv
// drop_timer bench: directed stimulus queues expected
// ticks; a monitor pops and checks on every tick.
module tb_drop_timer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  int         exp_cyc_q[$];
  logic [2:0] exp_cnt_q[$];
  logic [2:0] exp_cnt = 3'd0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  drop_timer_if #(.LEVEL_W(4), .CNT_W(3)) bus ();

  drop_timer #(
    .CLK_PER_UNIT(4),
    .BASE_UNITS(5),
    .STEP_UNITS(1),
    .MIN_UNITS(2),
    .SOFT_UNITS(1),
    .LEVEL_W(4),
    .CNT_W(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tmr(bus)
  );

  task automatic chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s act %0d req %0d", name, act, req);
    end
  endtask

  task automatic push(int at);
    exp_cnt = exp_cnt + 3'd1;
    exp_cyc_q.push_back(at);
    exp_cnt_q.push_back(exp_cnt);
  endtask

  task automatic wait_to(int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Monitor: every tick must match the next expectation.
  always @(negedge clk) begin
    if (rst && bus.tick) begin
      if (exp_cyc_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_tick act cyc %0d req none",
                 cyc);
      end else begin
        chk("tick_cycle", cyc, exp_cyc_q.pop_front());
        chk("tick_count", int'(bus.tick_count),
            int'(exp_cnt_q.pop_front()));
      end
    end
  end

  initial begin
    int e;
    bus.enable    = 1'b0;
    bus.pause     = 1'b0;
    bus.restart   = 1'b0;
    bus.soft_drop = 1'b0;
    bus.level     = 4'd0;
    repeat (2) @(negedge clk);
    chk("rst_tick", int'(bus.tick), 0);
    chk("rst_count", int'(bus.tick_count), 0);
    chk("rst_running", int'(bus.running), 0);
    chk("rst_paused", int'(bus.paused), 0);
    rst = 1'b1;
    @(negedge clk);

    // Level 0: 20-cycle period, counts 1,2,3.
    bus.enable = 1'b1;
    e = cyc + 1;
    push(e + 20);
    push(e + 40);
    push(e + 60);
    wait_to(e + 1);
    chk("running_a", int'(bus.running), 1);
    wait_to(e + 60);
    bus.enable = 1'b0;
    @(negedge clk);
    chk("idle_running", int'(bus.running), 0);
    chk("idle_hold_cnt", int'(bus.tick_count), 3);

    // Level 2 -> 12 cycles, then level 9 -> MIN, 8.
    bus.enable = 1'b1;
    bus.level  = 4'd2;
    e = cyc + 1;
    push(e + 12);
    push(e + 24);
    wait_to(e + 24);
    bus.level = 4'd9;
    push(e + 32);
    push(e + 40);
    wait_to(e + 40);
    bus.enable = 1'b0;
    @(negedge clk);

    // Level 0 -> 3 after 3 elapsed units.
    bus.enable = 1'b1;
    bus.level  = 4'd0;
    e = cyc + 1;
    wait_to(e + 12);
    bus.level = 4'd3;
    push(e + 16);
    push(e + 24);
    wait_to(e + 24);
    bus.enable = 1'b0;
    @(negedge clk);

    // Soft drop 4 cycles; release mid-interval.
    bus.enable    = 1'b1;
    bus.level     = 4'd0;
    bus.soft_drop = 1'b1;
    e = cyc + 1;
    push(e + 4);
    push(e + 8);
    push(e + 12);
    wait_to(e + 14);
    bus.soft_drop = 1'b0;
    push(e + 32);
    wait_to(e + 32);
    bus.enable = 1'b0;
    @(negedge clk);

    // Pause held 7 cycles from RUN cycle 10.
    bus.enable = 1'b1;
    e = cyc + 1;
    push(e + 27);
    wait_to(e + 9);
    bus.pause = 1'b1;
    wait_to(e + 10);
    chk("paused_on", int'(bus.paused), 1);
    chk("running_off", int'(bus.running), 0);
    wait_to(e + 16);
    chk("paused_hold", int'(bus.paused), 1);
    bus.pause = 1'b0;
    wait_to(e + 17);
    chk("paused_off", int'(bus.paused), 0);
    chk("running_back", int'(bus.running), 1);
    wait_to(e + 30);
    bus.pause = 1'b1;
    wait_to(e + 32);
    chk("paused_again", int'(bus.paused), 1);
    bus.enable = 1'b0;
    @(negedge clk);
    chk("idle_from_pause", int'(bus.paused), 0);
    chk("idle_not_run", int'(bus.running), 0);

    // Re-enable: cleared counters give a full period.
    bus.enable = 1'b1;
    bus.pause  = 1'b0;
    e = cyc + 1;
    push(e + 20);
    wait_to(e + 39);
    bus.restart = 1'b1;
    @(negedge clk);
    bus.restart = 1'b0;
    chk("restart_tick", int'(bus.tick), 0);
    chk("restart_count", int'(bus.tick_count), 0);
    exp_cnt = 3'd0;

    // Nine ticks after restart: 1..7, wrap to 0, 1.
    for (int k = 0; k < 9; k++) push(e + 60 + 20 * k);
    wait_to(e + 230);
    chk("pre_rst_count", int'(bus.tick_count), 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_tick", int'(bus.tick), 0);
    chk("arst_count", int'(bus.tick_count), 0);
    chk("arst_running", int'(bus.running), 0);
    chk("arst_paused", int'(bus.paused), 0);
    chk("missing_ticks", exp_cyc_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/drop_timer.md
# drop_timer

Parametrised gravity/drop timer for the Tetris game core. Divides the system clock into a base time unit, then counts a level-dependent number of units. At the end of each drop interval it emits a one-cycle `tick` that the game FSM uses to move the falling piece down one row. Supports level speed-up, soft-drop fast mode, pause/resume, synchronous restart, and a wrapping tick counter.

## Interface
Parameters:
- CLK_PER_UNIT, 1000000: clocks per time unit (20 ms at 50 MHz); must be ≥ 2
- BASE_UNITS, 10: drop period in units at level 0
- STEP_UNITS, 1: units removed from the period per level
- MIN_UNITS, 1: floor on the normal drop period; 1 ≤ MIN_UNITS ≤ BASE_UNITS
- SOFT_UNITS, 1: drop period in units while soft drop is active; ≥ 1
- LEVEL_W, 4: width of `level`
- CNT_W, 32: width of `tick_count`

Ports:
- clk  in  1  system clock, 50 MHz; all logic on the rising edge
- rst  in  1  asynchronous, active-low reset
- enable  in  1  high = timer may run; low = return to IDLE with counters cleared
- pause  in  1  level; high freezes counting while running
- restart  in  1  synchronous one-cycle clear of all counters
- soft_drop  in  1  level; selects the fast period
- level  in  LEVEL_W  current game level, unsigned
- tick  out  1  registered one-cycle pulse at the end of each drop interval
- tick_count  out  CNT_W  number of ticks since the last reset or restart; wraps modulo 2^CNT_W
- running  out  1  high in RUN
- paused  out  1  high in PAUSED

## Operation
- FSM states: IDLE, RUN, PAUSED. Reset state is IDLE.
  - IDLE → RUN when `enable`=1.
  - RUN → PAUSED when `pause`=1.
  - PAUSED → RUN when `pause`=0.
  - RUN/PAUSED → IDLE when `enable`=0.
- Input priority, evaluated each cycle:
  1. `restart`: clears `unit_cnt`, `drop_cnt` and `tick_count`; `tick` is 0; the state is unchanged.
  2. `enable`=0: go to IDLE, clear `unit_cnt` and `drop_cnt`; `tick_count` is held.
  3. `pause`.
- Internal counters:
  - `unit_cnt` counts 0 … CLK_PER_UNIT−1.
  - `drop_cnt` counts elapsed units in the current interval.
  - Both are sized by $clog2 of their maximum value.
- Normal period: `norm = max(MIN_UNITS, BASE_UNITS − level*STEP_UNITS)`.
  - Compute the product at full width (LEVEL_W plus the width of STEP_UNITS).
  - Saturate at MIN_UNITS; the subtraction must never underflow.
- Effective period: `period = soft_drop ? min(SOFT_UNITS, norm) : norm`. It is recomputed combinationally every cycle, with no latching.
- In RUN, each cycle:
  - `unit_cnt` increments.
  - When `unit_cnt` = CLK_PER_UNIT−1:
    - `unit_cnt` ← 0.
    - If `drop_cnt`+1 ≥ `period`: `drop_cnt` ← 0, `tick` ← 1, `tick_count` ← `tick_count`+1.
    - Otherwise `drop_cnt` ← `drop_cnt`+1.
- A mid-interval change of `level` or `soft_drop` that shortens the period to ≤ the elapsed units fires the tick at the next unit boundary. Ticks are never skipped or doubled.
- In PAUSED or IDLE, `unit_cnt` and `drop_cnt` hold (in IDLE they are zero). `tick` stays 0.

## Timing
- Reset values: `tick`=0, `tick_count`=0, `running`=0, `paused`=0; state IDLE; internal counters 0.
- `running` and `paused` are decoded registered state, valid the cycle after the transition edge.
- First RUN cycle is the cycle after `enable` is sampled high. With constant `period` P, `tick` is high in the cycle after the P·CLK_PER_UNIT-th RUN cycle, then every P·CLK_PER_UNIT RUN cycles thereafter.
- Cycles spent in PAUSED extend the interval by exactly that many cycles.
- `tick` is high for exactly one cycle. `tick_count` updates on the same edge that sets `tick`.
- `restart` on the edge where a tick would fire: no tick, and `tick_count` = 0.
- `tick_count` at 2^CNT_W−1 wraps to 0 on the next tick.

## Test plan
All tests use CLK_PER_UNIT=4, BASE_UNITS=5, STEP_UNITS=1, MIN_UNITS=2, SOFT_UNITS=1, CNT_W=3.
- Reset and enable: pulse `rst` low, then `enable`=1, `level`=0 → `tick` pulses every 20 cycles, the first in the cycle after the 20th RUN cycle; `tick_count` reads 1, 2, 3.
- Level scaling: `level`=2 → period 12 cycles. `level`=9 → clamped to MIN, period 8 cycles. Change `level` 0→3 at elapsed unit 3 → tick at the next unit boundary (cycle 16).
- Soft drop: hold `soft_drop`=1 → tick every 4 cycles. Release it mid-interval → the normal period resumes with no double tick.
- Pause: assert `pause` for 7 cycles at RUN cycle 10 → `paused`=1 during that window, and the tick arrives at cycle 27 instead of 20. `enable`=0 in PAUSED → IDLE, counters cleared.
- Restart and wrap: `restart` on the would-be tick edge → no tick, `tick_count`=0. Run 8 ticks → `tick_count` wraps 7→0. Async `rst` low mid-interval → all outputs 0 immediately.
